// File: rtl/uart_tx_framer_pkg.sv
// Shared definitions for the UART transmit framer: one-hot state encoding
// and the default frame-format constants used by the interface circuit.
package uart_tx_framer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_e;

  localparam int WIDTH_WORD_INTERFACE = 8;
  localparam int OVERSAMPLE           = 16;
  localparam int STOP_TICKS_1         = 16;
  localparam int STOP_TICKS_1P5       = 24;
  localparam int STOP_TICKS_2         = 32;

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmitter: latches one word per start/armed handshake and shifts it
// out as start, data (LSB first), optional parity and stop, paced by i_tick.
//
// state  | meaning
// IDLE   | line high, waiting for start while armed
// START  | start bit (low) for OVERSAMPLE ticks
// DATA   | current data bit, WIDTH_WORD bit periods
// PARITY | parity bit for OVERSAMPLE ticks (PARITY_EN only)
// STOP   | line high for STOP_TICKS ticks, then done pulse
module uart_tx_framer #(
  parameter int WIDTH_WORD = uart_tx_framer_pkg::WIDTH_WORD_INTERFACE,
  parameter int OVERSAMPLE = uart_tx_framer_pkg::OVERSAMPLE,
  parameter int STOP_TICKS = uart_tx_framer_pkg::STOP_TICKS_1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_tx_start,
  input  logic [WIDTH_WORD-1:0] i_data_tx,
  output logic                  o_tx,
  output logic                  o_tx_done,
  output logic                  o_busy
);
  import uart_tx_framer_pkg::*;

  localparam int TICK_MAX = (STOP_TICKS > OVERSAMPLE) ? STOP_TICKS : OVERSAMPLE;
  localparam int TICK_W   = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = $clog2(WIDTH_WORD + 1);

  localparam logic [TICK_W-1:0] BIT_RELOAD  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_RELOAD = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(WIDTH_WORD - 1);
  localparam logic              ODD_BIT     = (PARITY_ODD != 0);

  state_e                r_state;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [WIDTH_WORD-1:0] r_shift;
  logic                  r_parity;
  logic                  r_armed;
  logic                  r_tx;
  logic                  r_tx_done;
  logic                  r_busy;
  logic                  w_tick_tc;

  // Tick timer is a down-counter; a period ends on the tick that finds it at zero.
  assign w_tick_tc = i_tick && (r_tick_cnt == '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_armed    <= 1'b1;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_tx_start) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_shift    <= i_data_tx;
            r_parity   <= (^i_data_tx) ^ ODD_BIT;
            r_tick_cnt <= BIT_RELOAD;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick_tc) begin
            r_tick_cnt <= BIT_RELOAD;
            r_bit_cnt  <= '0;
            r_tx       <= r_shift[0];
            r_state    <= ST_DATA;
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt - TICK_W'(1);
          end
        end
        ST_DATA: begin
          if (w_tick_tc) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt != LAST_BIT) begin
              r_tick_cnt <= BIT_RELOAD;
              r_tx       <= r_shift[1];
            end else if (PARITY_EN != 0) begin
              r_tick_cnt <= BIT_RELOAD;
              r_tx       <= r_parity;
              r_state    <= ST_PARITY;
            end else begin
              r_tick_cnt <= STOP_RELOAD;
              r_tx       <= 1'b1;
              r_state    <= ST_STOP;
            end
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt - TICK_W'(1);
          end
        end
        ST_PARITY: begin
          if (w_tick_tc) begin
            r_tick_cnt <= STOP_RELOAD;
            r_tx       <= 1'b1;
            r_state    <= ST_STOP;
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt - TICK_W'(1);
          end
        end
        ST_STOP: begin
          // Disarm so a start held across done needs a low cycle before the next frame.
          if (w_tick_tc) begin
            r_tx_done <= 1'b1;
            r_busy    <= 1'b0;
            r_armed   <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt - TICK_W'(1);
          end
        end
        default: begin
          r_tick_cnt <= '0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_done = r_tx_done;
  assign o_busy    = r_busy;

endmodule
